// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready handshake, flush and NOP bubbles.
// SKID=1 uses a 2-entry skid buffer so in_ready comes straight from flops.
module pipe_stage_reg #(
    parameter int unsigned DATA_W    = 32,
    parameter logic [31:0] NOP_VALUE = 32'h0000_0013,
    parameter bit          SKID      = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy
);

    localparam logic [DATA_W-1:0] NopData = DATA_W'(NOP_VALUE);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } state_e;

    logic              accept;
    logic              send;
    logic [DATA_W-1:0] m_q, m_d;

    assign accept   = in_valid & in_ready;
    assign send     = out_valid & out_ready;
    assign out_data = out_valid ? m_q : NopData;

    if (SKID) begin : g_skid
        state_e            state_q, state_d;
        logic [DATA_W-1:0] s_q, s_d;

        always_comb begin
            state_d = state_q;
            m_d     = m_q;
            s_d     = s_q;
            if (flush) begin
                // Flush wins: any payload offered this cycle is dropped.
                state_d = StEmpty;
            end else begin
                unique case (state_q)
                    StEmpty: begin
                        if (accept) begin
                            state_d = StOne;
                            m_d     = in_data;
                        end
                    end
                    StOne: begin
                        if (accept && send) begin
                            m_d = in_data;
                        end else if (accept) begin
                            state_d = StFull;
                            s_d     = in_data;
                        end else if (send) begin
                            state_d = StEmpty;
                        end
                    end
                    StFull: begin
                        if (send) begin
                            state_d = StOne;
                            m_d     = s_q;
                        end
                    end
                    default: state_d = StEmpty;
                endcase
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= StEmpty;
                m_q     <= '0;
                s_q     <= '0;
            end else begin
                state_q <= state_d;
                m_q     <= m_d;
                s_q     <= s_d;
            end
        end

        assign in_ready  = (state_q != StFull);
        assign out_valid = (state_q != StEmpty);
        assign occupancy = (state_q == StFull) ? 2'd2 :
                           (state_q == StOne)  ? 2'd1 : 2'd0;
    end else begin : g_single
        logic valid_q, valid_d;

        always_comb begin
            valid_d = valid_q;
            m_d     = m_q;
            if (flush) begin
                valid_d = 1'b0;
            end else if (accept) begin
                valid_d = 1'b1;
                m_d     = in_data;
            end else if (send) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                m_q     <= '0;
            end else begin
                valid_q <= valid_d;
                m_q     <= m_d;
            end
        end

        // Combinational ready: a draining entry frees the slot this cycle.
        assign in_ready  = ~valid_q | out_ready;
        assign out_valid = valid_q;
        assign occupancy = {1'b0, valid_q};
    end

endmodule
